// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: NOP encoding, default reset PC,
// fetch FSM state encoding and the IF/ID record used by fetch and decode.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHalt = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: fetch drives the word index, memory returns
// the word combinationally.
interface instruction_fetch_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/pc_register.sv
// Program counter: word-aligned flop with synchronous reset, next-PC mux
// (redirect > hold > +4) and the +4 adder shared with the IF/ID pc4 field.
module pc_register #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    input  logic                  i_hold,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4
);
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;

    // Wraps naturally modulo 2^ADDR_WIDTH.
    assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (i_redirect) begin
            w_pc_next = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else if (i_hold) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = w_pc_plus4;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction-memory index, and loads the
// IF/ID register under stall/flush/redirect/halt control.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    input  logic                   i_halt,
    instruction_fetch_if.master    imem,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [DATA_WIDTH-1:0]  o_ifid_instr,
    output logic [ADDR_WIDTH-1:0]  o_ifid_pc4,
    output logic                   o_ifid_valid,
    output logic                   o_halted,
    output logic [31:0]            o_fetch_count
);
    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic                  w_stopping;
    logic                  w_redirect;
    logic                  w_hold;
    logic                  w_bubble;
    logic                  w_load;
    logic [ADDR_WIDTH-1:0] w_pc;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;

    logic [DATA_WIDTH-1:0] r_ifid_instr;
    logic [ADDR_WIDTH-1:0] r_ifid_pc4;
    logic                  r_ifid_valid;
    logic [31:0]           r_fetch_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A halt request takes effect at the very edge it is sampled on, so the PC
    // is frozen and any same-cycle redirect is dropped.
    always_comb begin
        w_state_next = r_state;
        w_stopping   = 1'b0;
        unique case (r_state)
            StRun: begin
                if (i_halt) begin
                    w_state_next = StHalt;
                    w_stopping   = 1'b1;
                end
            end
            StHalt: w_stopping = 1'b1;
            default: w_state_next = StRun;
        endcase
    end

    assign w_redirect = i_redirect & ~w_stopping;
    assign w_hold     = i_stall | w_stopping;
    assign w_bubble   = w_stopping | w_redirect | i_flush;
    assign w_load     = ~w_bubble & ~i_stall;

    pc_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_register (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_redirect    (w_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_hold        (w_hold),
        .o_pc          (w_pc),
        .o_pc_plus4    (w_pc_plus4)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ifid_instr <= DATA_WIDTH'(INSTR_NOP);
            r_ifid_pc4   <= '0;
            r_ifid_valid <= 1'b0;
        end else if (w_bubble) begin
            r_ifid_instr <= DATA_WIDTH'(INSTR_NOP);
            r_ifid_pc4   <= '0;
            r_ifid_valid <= 1'b0;
        end else if (w_load) begin
            r_ifid_instr <= imem.imem_data;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_valid <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_count <= '0;
        end else if (w_load && (r_fetch_count != 32'hFFFF_FFFF)) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem.imem_addr = {2'b00, w_pc[ADDR_WIDTH-1:2]};
    assign o_pc           = w_pc;
    assign o_ifid_instr   = r_ifid_instr;
    assign o_ifid_pc4     = r_ifid_pc4;
    assign o_ifid_valid   = r_ifid_valid;
    assign o_halted       = (r_state == StHalt);
    assign o_fetch_count  = r_fetch_count;
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the pipelined MIPS core and the requesting end of the instruction-memory read port. It holds the PC and drives the word index to instruction memory. It captures the returned word into the IF/ID pipeline register. It also applies stall, flush, redirect and halt requests from later stages.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, PC and memory index width
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_stall  in  1  hold PC and IF/ID (load-use hazard)
- i_flush  in  1  replace the next IF/ID contents with a bubble
- i_redirect  in  1  taken branch or jump resolved downstream
- i_redirect_pc  in  ADDR_WIDTH  byte target address; bits [1:0] ignored
- i_halt  in  1  stop fetching until reset (break/syscall decoded)
- o_imem_addr  out  ADDR_WIDTH  word index to instruction memory = pc >> 2
- i_imem_data  in  DATA_WIDTH  combinational read data from instruction memory
- o_pc  out  ADDR_WIDTH  current PC (byte address)
- o_ifid_instr  out  DATA_WIDTH  registered instruction
- o_ifid_pc4  out  ADDR_WIDTH  registered PC+4 of that instruction
- o_ifid_valid  out  1  IF/ID holds a real instruction
- o_halted  out  1  FSM is in HALT
- o_fetch_count  out  32  number of instructions delivered to IF/ID, saturating

## Operation
- FSM states: RUN, HALT. Reset enters RUN. RUN→HALT on i_halt (not gated by i_stall). HALT is left only by reset.
- The PC register always holds a byte address with bits [1:0] = 0. o_imem_addr = {2'b00, pc[ADDR_WIDTH-1:2]}, combinational from the PC.
- Next-PC priority per cycle in RUN:
  - i_redirect → {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00}
  - else i_stall → pc
  - else pc + 4, modulo 2^ADDR_WIDTH; 0xFFFF_FFFC wraps to 0
- IF/ID update priority per cycle:
  - HALT, or i_redirect, or i_flush → bubble: instr = NOP (all zeros), pc4 = 0, valid = 0
  - else i_stall → hold all three fields
  - else load instr = i_imem_data, pc4 = pc + 4, valid = 1
- i_redirect overrides i_stall for both the PC and IF/ID. i_flush overrides i_stall for IF/ID only; under flush+stall the PC holds.
- In HALT the PC freezes and all redirect, stall and flush requests are ignored.
- o_fetch_count increments whenever IF/ID loads with valid = 1. It saturates at 0xFFFF_FFFF.

## Timing
- Reset values (cycle after i_rst sampled high):
  - o_pc = RESET_PC; o_imem_addr = RESET_PC >> 2
  - o_ifid_instr = 0, o_ifid_pc4 = 0, o_ifid_valid = 0
  - o_halted = 0, o_fetch_count = 0
- Reset is synchronous, wins over every other input and may be asserted mid-operation. Any pending redirect or halt is discarded.
- Fetch latency: the word addressed in cycle N appears on o_ifid_* after edge N+1.
- Redirect asserted in cycle N: the PC equals the target after edge N+1. The wrong-path word fetched in cycle N is replaced by a bubble. The first target-path instruction is valid in IF/ID after edge N+2.
- Halt asserted in cycle N: o_halted = 1 and o_ifid_valid = 0 after edge N+1. The PC keeps its cycle-N value.
- Back-to-back stalls hold indefinitely, with no lost or duplicated instruction.

## Structure
- Shared package mips_pkg:
  - INSTR_NOP = 32'h0000_0000
  - DEFAULT_RESET_PC
  - fetch state encoding (RUN, HALT)
  - IF/ID record type {instr, pc4, valid}, reused by the decode stage
- One sub-module, pc_register: PC flop with synchronous reset, next-PC mux and +4 adder.
- IF/ID register, FSM and counter live in instruction_fetch.

## Test plan
- Reset then free run with memory words 0x20080001, 0x20090002, 0x01095020 at indices 0–2 → IF/ID shows them on cycles 1, 2, 3 with pc4 = 4, 8, 12; o_fetch_count = 3.
- i_stall high for 3 cycles while pc = 8 → o_pc stays 8; IF/ID holds pc4 = 8 and the same instr. Fetch resumes at 8 with no skipped or duplicated word.
- i_redirect with i_redirect_pc = 0x0000_0043 at pc = 12 → next pc = 0x40, o_imem_addr = 0x10. The next IF/ID is a bubble (valid 0), then the word at index 0x10 with pc4 = 0x44. Also assert i_stall in the same cycle → identical result.
- i_flush together with i_stall → IF/ID becomes a bubble, pc holds, o_fetch_count unchanged.
- RESET_PC = 32'hFFFF_FFF8, free run → pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- i_halt at pc = 0x20, then pulse i_redirect → o_halted = 1, pc stays 0x20, valid stays 0. i_rst one cycle → all outputs at their reset values and fetch restarts at RESET_PC.
